riscv_mem_responder: RTL and testbench

//  Memory-side responder for the multi-cycle RISC-V core's load/store/fetch port.

---
 rtl/riscv_mem_pkg.sv | 21 ++
 rtl/mem_word_array.sv | 27 ++
 rtl/riscv_mem_responder.sv | 136 +++++++++++++
 tb/tb_riscv_mem_responder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the RISC-V memory responder: size codes, FSM states
// and the byte-enable builder used by the store path.
package riscv_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << lo;
      SZ_HALF: byte_en = lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word-organised storage with per-byte write enables and an asynchronous read;
// contents are deliberately left unreset.
module mem_word_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/riscv_mem_responder.sv
// Single-outstanding memory responder with programmable wait states, byte-enabled
// stores and sign/zero-extended loads for the multi-cycle RISC-V core.
module riscv_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  LAT_M1   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [31:0] ADDR_LIM = 32'(4 * DEPTH_WORDS);

  state_t      state;
  logic [3:0]  cnt;
  logic        l_write, l_uns;
  logic [31:0] l_addr, l_wdata;
  logic [1:0]  l_size;

  // With LATENCY==0 the response is built on the accept edge itself, so the
  // datapath looks at the live request while idle and the latched one otherwise.
  logic        c_write, c_uns;
  logic [31:0] c_addr, c_wdata;
  logic [1:0]  c_size;

  assign c_write = (state == IDLE) ? req_write    : l_write;
  assign c_uns   = (state == IDLE) ? req_unsigned : l_uns;
  assign c_addr  = (state == IDLE) ? req_addr     : l_addr;
  assign c_wdata = (state == IDLE) ? req_wdata    : l_wdata;
  assign c_size  = (state == IDLE) ? req_size     : l_size;

  logic accept, err, to_resp, we;
  assign accept = req_valid & req_ready;

  always_comb begin
    err = 1'b0;
    if (c_size == SZ_ILL)                       err = 1'b1;
    if (c_size == SZ_HALF && c_addr[0])         err = 1'b1;
    if (c_size == SZ_WORD && c_addr[1:0] != 0)  err = 1'b1;
    if (c_addr >= ADDR_LIM)                     err = 1'b1;
  end

  assign to_resp = (state == IDLE && accept && LATENCY == 0) ||
                   (state == WAIT && cnt == 4'd0);
  // Gating with reset keeps a store from committing on an edge that races reset.
  assign we = to_resp & c_write & ~err & reset;

  logic [31:0] wword, rword, shifted, load_data, resp_data;

  always_comb begin
    case (c_size)
      SZ_BYTE: wword = {4{c_wdata[7:0]}};
      SZ_HALF: wword = {2{c_wdata[15:0]}};
      default: wword = c_wdata;
    endcase
  end

  mem_word_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (we),
    .be    (byte_en(c_size, c_addr[1:0])),
    .addr  (c_addr[AW+1:2]),
    .wdata (wword),
    .rdata (rword)
  );

  always_comb begin
    shifted = rword >> {c_addr[1:0], 3'b000};
    case (c_size)
      SZ_BYTE: load_data = c_uns ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = c_uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = rword;
    endcase
    resp_data = (err || c_write) ? 32'd0 : load_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_error <= 1'b0;
      l_write   <= 1'b0;
      l_uns     <= 1'b0;
      l_addr    <= 32'd0;
      l_wdata   <= 32'd0;
      l_size    <= SZ_BYTE;
    end else begin
      case (state)
        IDLE: if (accept) begin
          l_write   <= req_write;
          l_uns     <= req_unsigned;
          l_addr    <= req_addr;
          l_wdata   <= req_wdata;
          l_size    <= req_size;
          req_ready <= 1'b0;
          cnt       <= LAT_M1;
          state     <= (LATENCY == 0) ? RESP : WAIT;
        end
        WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
              else             state <= RESP;
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      if (to_resp) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= resp_data;
        rsp_error <= err;
      end else if (state == RESP) begin
        rsp_valid <= 1'b0;
        rsp_rdata <= 32'd0;
        rsp_error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Randomized bench for riscv_mem_responder against a byte-addressed reference
// memory; a second LATENCY=0 instance covers the zero-wait back-to-back timing.
module tb_riscv_mem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 1024;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;

  logic        b_req_valid, b_req_ready, b_req_write, b_req_unsigned;
  logic [31:0] b_req_addr, b_req_wdata;
  logic [1:0]  b_req_size;
  logic        b_rsp_valid, b_rsp_error;
  logic [31:0] b_rsp_rdata;

  riscv_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error)
  );

  riscv_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut0 (
    .clk(clk), .reset(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_size(b_req_size), .req_unsigned(b_req_unsigned),
    .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .rsp_error(b_rsp_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] ref_mem [DEPTH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit model_err(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 3) || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0) || (a >= 4 * DEPTH);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input bit u);
    int nb = 1 << sz;
    logic [31:0] v = 0, w, mask;
    for (int k = 0; k < nb; k++) begin
      w = ref_mem[(a + k) / 4];
      v = v | (((w >> (8 * ((a + k) % 4))) & 32'hFF) << (8 * k));
    end
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 1);
    if (nb < 4 && !u && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    int nb = 1 << sz;
    for (int k = 0; k < nb; k++)
      ref_mem[(a + k) / 4][8*((a + k) % 4) +: 8] = 8'((d >> (8 * k)) & 32'hFF);
  endtask

  // One transaction on the LATENCY=2 instance; the request fields are scrambled
  // (with req_valid high) while busy to show they are neither sampled nor accepted.
  task automatic xact(input bit w, input logic [31:0] a, input logic [1:0] sz,
                      input bit u, input logic [31:0] wd, output logic [31:0] rd);
    bit got = 0;
    logic [31:0] exp_d;
    bit exp_e;
    exp_e = model_err(a, sz);
    exp_d = (w || exp_e) ? 32'd0 : model_load(a, sz, u);
    rd = 32'hx;
    @(negedge clk);
    chk("ready_idle", req_ready, 1);
    req_valid = 1; req_write = w; req_addr = a; req_size = sz;
    req_unsigned = u; req_wdata = wd;
    @(posedge clk);
    for (int n = 1; n <= 20 && !got; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1;
        rd = rsp_rdata;
        chk("latency", n, LAT + 1);
        chk("rdata", rsp_rdata, exp_d);
        chk("error", rsp_error, exp_e);
        req_valid = 0;
      end else begin
        chk("busy_ready", req_ready, 0);
        chk("quiet_rdata", rsp_rdata, 0);
        chk("quiet_error", rsp_error, 0);
        req_valid = 1; req_write = 1'($urandom); req_addr = $urandom;
        req_size = 2'($urandom); req_unsigned = 1'($urandom); req_wdata = $urandom;
      end
    end
    if (!got) chk("rsp_timeout", 0, 1);
    if (w && !exp_e) model_store(a, sz, wd);
  endtask

  initial begin
    logic [31:0] rd, a, d;
    logic [1:0]  sz;
    bit          w, u;
    int          r;

    rst_n = 0;
    req_valid = 0; req_write = 0; req_addr = 0; req_size = 0; req_unsigned = 0; req_wdata = 0;
    b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_size = 0; b_req_unsigned = 0; b_req_wdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_error", rsp_error, 0);
    rst_n = 1;

    for (int i = 0; i < 64; i++) xact(1, 32'(4 * i), 2, 0, $urandom, rd);

    xact(1, 32'h100, 2, 0, 32'hDEADBEEF, rd);
    xact(0, 32'h100, 2, 0, 0, rd);  chk("spec_lw", rd, 32'hDEADBEEF);
    xact(1, 32'h101, 0, 0, 32'h5A, rd);
    xact(0, 32'h100, 2, 0, 0, rd);  chk("spec_sb_lw", rd, 32'hDEAD5AEF);
    xact(0, 32'h102, 1, 0, 0, rd);  chk("spec_lh", rd, 32'hFFFFDEAD);
    xact(0, 32'h102, 1, 1, 0, rd);  chk("spec_lhu", rd, 32'h0000DEAD);
    xact(0, 32'h100, 0, 0, 0, rd);  chk("spec_lb", rd, 32'hFFFFFFEF);
    xact(1, 32'h102, 2, 0, 32'h12345678, rd);
    xact(0, 32'h100, 2, 0, 0, rd);  chk("spec_unchanged", rd, 32'hDEAD5AEF);
    xact(0, 32'h1000, 2, 0, 0, rd); chk("spec_oor", rd, 0);
    xact(0, 32'h104, 3, 0, 0, rd);  chk("spec_size3", rd, 0);
    xact(0, 32'hFFC, 2, 1, 0, rd);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'h1000 + $urandom_range(0, 255);
      else if (r == 1) a = $urandom;
      else             a = $urandom_range(0, 255);
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0 && sz != 3) a = a & ~((32'd1 << sz) - 1);
      w = 1'($urandom); u = 1'($urandom); d = $urandom;
      xact(w, a, sz, u, d, rd);
    end

    // Reset one cycle after a store is accepted: the store must be dropped.
    @(negedge clk);
    req_valid = 1; req_write = 1; req_addr = 0; req_size = 2; req_wdata = 32'h11111111;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    rst_n = 0;
    #1;
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_valid", rsp_valid, 0);
    @(negedge clk);
    rst_n = 1;
    r = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid) r++;
    end
    chk("mid_rst_no_rsp", r, 0);
    chk("mid_rst_ready_after", req_ready, 1);
    xact(0, 0, 2, 0, 0, rd);

    // Zero-latency instance: accept, respond next cycle, accept again every 2 cycles.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("l0_ready", b_req_ready, (i % 2 == 0));
      chk("l0_valid", b_rsp_valid, (i % 2 == 1));
      if (i % 2 == 1) chk("l0_rdata", b_rsp_rdata, (i == 1) ? 32'd0 : 32'hCAFEF00D);
      b_req_valid = 1; b_req_addr = 0; b_req_size = 2;
      b_req_write = (i == 0); b_req_wdata = 32'hCAFEF00D;
    end
    b_req_valid = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
